byte_serializer: RTL

BYTE_SERIALIZER -- requirements
Module: byte_serializer

---
 rtl/byte_serializer.sv | 79 +++++++
 1 files changed

// File: rtl/byte_serializer.sv
// byte_serializer: 2-entry FIFO feeding an MSB-first bit serializer with a
// clock divider per bit slot and optional idle slots between bytes.
module byte_serializer #(
  parameter int CLK_DIV = 1,
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ser_data,
  output logic       ser_enable,
  output logic       byte_done,
  output logic       busy,
  output logic [1:0] fifo_level
);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP_WAIT} state_t;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [11:0] GAP_LAST = 12'(GAP * CLK_DIV - 1);
  state_t state;
  logic [7:0] mem [2];
  logic wr_ptr, rd_ptr;
  logic [1:0] count;
  logic [7:0] sr, div;
  logic [2:0] bit_cnt;
  logic [11:0] gap_cnt;
  logic strobe, last, gap_end, load, push;
  assign strobe = state == SHIFT && div == DIV_LAST;
  assign last = strobe && bit_cnt == 3'd7;
  assign gap_end = state == GAP_WAIT && gap_cnt == GAP_LAST;
  // a load pops the FIFO head straight into the shift register
  assign load = count != 2'd0 && (state == IDLE || (last && GAP == 0) || gap_end);
  assign in_ready = reset_n && count != 2'd2;
  assign push = in_valid && in_ready;
  assign ser_enable = strobe;
  assign ser_data = strobe & sr[7];
  assign byte_done = last;
  assign busy = state != IDLE || count != 2'd0;
  assign fifo_level = count;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
      sr <= 8'h00;
      div <= 8'd0;
      bit_cnt <= 3'd0;
      gap_cnt <= 12'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr <= ~wr_ptr;
      end
      if (load) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, load};
      if (load) begin
        sr <= mem[rd_ptr];
        div <= 8'd0;
        bit_cnt <= 3'd0;
        state <= SHIFT;
      end else if (strobe) begin
        sr <= {sr[6:0], 1'b0};
        div <= 8'd0;
        bit_cnt <= bit_cnt + 3'd1;
        if (last) begin
          state <= GAP > 0 ? GAP_WAIT : IDLE;
          gap_cnt <= 12'd0;
        end
      end else if (state == SHIFT) begin
        div <= div + 8'd1;
      end else if (state == GAP_WAIT) begin
        if (gap_end) state <= IDLE;
        else gap_cnt <= gap_cnt + 12'd1;
      end
    end
  end
endmodule
